// File: rtl/cdb_rr.sv
// cdb_rr - common data bus with round-robin low-priority arbitration.
//
// One max-priority source and LP_N low-priority sources compete for a
// single registered broadcast that the ROB, the reservation stations and
// the issue-queue logic all snoop. The low-priority sources take turns in
// round-robin order. A bounded streak counter stops the max-priority
// source from starving them.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   flush_i              pipeline flush: drops the held result, grants nothing
//   mp_*                 max-priority source (valid/ready + payload)
//   lp_*                 LP_N low-priority sources, packed per source
//   cdb_*                registered broadcast (valid/ready + payload + source)
//   dbg_rr_ptr           current round-robin pointer
//   dbg_streak           current max-priority streak count
//
// Handshake: a transfer happens in a cycle where valid && ready are both
// high. Readys are computed combinationally from the valids, cdb_ready_i,
// flush_i and internal state. A ready is never high without its valid.
// Sources keep valid and payload stable until they see ready. The
// broadcast side holds valid and payload stable while cdb_ready_i is low.

module cdb_rr #(
    parameter int LP_N        = 4,
    parameter int XLEN        = 64,
    parameter int ROB_IDX_LEN = 6,
    parameter int MAX_STREAK  = 4,
    localparam int PTR_W      = (LP_N > 1) ? $clog2(LP_N) : 1,
    localparam int SRC_W      = $clog2(LP_N + 1),
    localparam int STREAK_W   = $clog2(MAX_STREAK + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,

    input  logic                        mp_valid_i,
    output logic                        mp_ready_o,
    input  logic [ROB_IDX_LEN-1:0]      mp_rob_idx_i,
    input  logic [XLEN-1:0]             mp_value_i,
    input  logic                        mp_except_i,

    input  logic [LP_N-1:0]             lp_valid_i,
    output logic [LP_N-1:0]             lp_ready_o,
    input  logic [LP_N*ROB_IDX_LEN-1:0] lp_rob_idx_i,
    input  logic [LP_N*XLEN-1:0]        lp_value_i,
    input  logic [LP_N-1:0]             lp_except_i,

    output logic                        cdb_valid_o,
    input  logic                        cdb_ready_i,
    output logic [ROB_IDX_LEN-1:0]      cdb_rob_idx_o,
    output logic [XLEN-1:0]             cdb_value_o,
    output logic                        cdb_except_o,
    output logic [SRC_W-1:0]            cdb_src_o,

    output logic [PTR_W-1:0]            dbg_rr_ptr,
    output logic [STREAK_W-1:0]         dbg_streak
);

    logic [PTR_W-1:0]    rr_ptr;
    logic [STREAK_W-1:0] streak;

    logic                free;
    logic                can_grant;
    logic                lp_any;
    logic                streak_full;
    logic                lp_found;
    logic [PTR_W-1:0]    lp_sel;
    logic                mp_win;
    logic                lp_win;

    assign free        = !cdb_valid_o || cdb_ready_i;
    // Reset also blocks grants so no source believes it was accepted.
    assign can_grant   = free && !flush_i && !rst_i;
    assign lp_any      = |lp_valid_i;
    assign streak_full = (streak == STREAK_W'(MAX_STREAK));

    // First requesting low-priority source, searching upward from rr_ptr.
    always_comb begin
        lp_found = 1'b0;
        lp_sel   = '0;
        for (int i = 0; i < LP_N; i++) begin
            if (!lp_found && lp_valid_i[(int'(rr_ptr) + i) % LP_N]) begin
                lp_found = 1'b1;
                lp_sel   = PTR_W'((int'(rr_ptr) + i) % LP_N);
            end
        end
    end

    // Max-priority yields only once its streak has saturated while a
    // low-priority source is waiting.
    assign mp_win = can_grant && mp_valid_i && !(streak_full && lp_any);
    assign lp_win = can_grant && lp_found && !mp_win;

    assign mp_ready_o = mp_win;

    always_comb begin
        lp_ready_o = '0;
        if (lp_win) begin
            lp_ready_o[lp_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cdb_valid_o   <= 1'b0;
            cdb_rob_idx_o <= '0;
            cdb_value_o   <= '0;
            cdb_except_o  <= 1'b0;
            cdb_src_o     <= '0;
            rr_ptr        <= '0;
            streak        <= '0;
        end else if (flush_i) begin
            // Held result is dropped even if the ROB is accepting it now.
            cdb_valid_o <= 1'b0;
            streak      <= '0;
        end else begin
            if (free) begin
                cdb_valid_o <= mp_win || lp_win;
            end
            if (mp_win) begin
                cdb_rob_idx_o <= mp_rob_idx_i;
                cdb_value_o   <= mp_value_i;
                cdb_except_o  <= mp_except_i;
                cdb_src_o     <= '0;
            end else if (lp_win) begin
                cdb_rob_idx_o <= lp_rob_idx_i[lp_sel*ROB_IDX_LEN +: ROB_IDX_LEN];
                cdb_value_o   <= lp_value_i[lp_sel*XLEN +: XLEN];
                cdb_except_o  <= lp_except_i[lp_sel];
                cdb_src_o     <= SRC_W'(int'(lp_sel) + 1);
                rr_ptr        <= PTR_W'((int'(lp_sel) + 1) % LP_N);
            end

            // Streak counts only max-priority wins that made someone wait.
            if (lp_win || !lp_any) begin
                streak <= '0;
            end else if (mp_win && !streak_full) begin
                streak <= streak + STREAK_W'(1);
            end
        end
    end

    assign dbg_rr_ptr = rr_ptr;
    assign dbg_streak = streak;

endmodule

// File: tb/tb_cdb_rr.sv
// tb_cdb_rr - directed-vector bench for cdb_rr with LP_N=4, MAX_STREAK=4.
//
// Inputs change one time unit after a rising edge; readys are sampled after
// the combinational logic settles and registered outputs are sampled one
// time unit after the following rising edge.

module tb_cdb_rr;

    localparam int LP_N        = 4;
    localparam int XLEN        = 64;
    localparam int ROB_IDX_LEN = 6;
    localparam int MAX_STREAK  = 4;

    logic                        clk;
    logic                        rst;
    logic                        flush;
    logic                        mp_valid;
    logic                        mp_ready;
    logic [ROB_IDX_LEN-1:0]      mp_rob_idx;
    logic [XLEN-1:0]             mp_value;
    logic                        mp_except;
    logic [LP_N-1:0]             lp_valid;
    logic [LP_N-1:0]             lp_ready;
    logic [LP_N*ROB_IDX_LEN-1:0] lp_rob_idx;
    logic [LP_N*XLEN-1:0]        lp_value;
    logic [LP_N-1:0]             lp_except;
    logic                        cdb_valid;
    logic                        cdb_ready;
    logic [ROB_IDX_LEN-1:0]      cdb_rob_idx;
    logic [XLEN-1:0]             cdb_value;
    logic                        cdb_except;
    logic [2:0]                  cdb_src;
    logic [1:0]                  dbg_rr_ptr;
    logic [2:0]                  dbg_streak;

    int n_vec;
    int n_err;

    cdb_rr #(
        .LP_N       (LP_N),
        .XLEN       (XLEN),
        .ROB_IDX_LEN(ROB_IDX_LEN),
        .MAX_STREAK (MAX_STREAK)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .mp_valid_i   (mp_valid),
        .mp_ready_o   (mp_ready),
        .mp_rob_idx_i (mp_rob_idx),
        .mp_value_i   (mp_value),
        .mp_except_i  (mp_except),
        .lp_valid_i   (lp_valid),
        .lp_ready_o   (lp_ready),
        .lp_rob_idx_i (lp_rob_idx),
        .lp_value_i   (lp_value),
        .lp_except_i  (lp_except),
        .cdb_valid_o  (cdb_valid),
        .cdb_ready_i  (cdb_ready),
        .cdb_rob_idx_o(cdb_rob_idx),
        .cdb_value_o  (cdb_value),
        .cdb_except_o (cdb_except),
        .cdb_src_o    (cdb_src),
        .dbg_rr_ptr   (dbg_rr_ptr),
        .dbg_streak   (dbg_streak)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checking
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] src);
        check({tag, ".valid"}, 64'(cdb_valid), 64'(v));
        check({tag, ".src"}, 64'(cdb_src), 64'(src));
    endtask

    // Stimulus
    initial begin
        int exp_src[5];
        int ast_src[10];
        n_vec = 0;
        n_err = 0;

        rst       = 1'b1;
        flush     = 1'b0;
        mp_valid  = 1'b1;
        mp_rob_idx = 6'd7;
        mp_value  = 64'hBEEF;
        mp_except = 1'b0;
        lp_valid  = 4'b1111;
        lp_except = 4'b0000;
        cdb_ready = 1'b1;
        for (int k = 0; k < LP_N; k++) begin
            lp_rob_idx[k*ROB_IDX_LEN +: ROB_IDX_LEN] = ROB_IDX_LEN'(10 + k);
            lp_value[k*XLEN +: XLEN] = 64'h100 + 64'(k);
        end

        // Reset held two cycles with every valid high.
        tick();
        check("rst.mp_ready_c1", 64'(mp_ready), 64'd0);
        check("rst.lp_ready_c1", 64'(lp_ready), 64'd0);
        tick();
        check("rst.mp_ready_c2", 64'(mp_ready), 64'd0);
        check("rst.lp_ready_c2", 64'(lp_ready), 64'd0);
        check("rst.cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst.rr_ptr", 64'(dbg_rr_ptr), 64'd0);
        check("rst.streak", 64'(dbg_streak), 64'd0);
        check("rst.src", 64'(cdb_src), 64'd0);
        check("rst.value", cdb_value, 64'd0);
        check("rst.rob_idx", 64'(cdb_rob_idx), 64'd0);
        check("rst.except", 64'(cdb_except), 64'd0);

        // Round-robin fairness: all four low-priority sources requesting.
        rst = 1'b0;
        mp_valid = 1'b0;
        lp_valid = 4'b1111;
        exp_src = '{1, 2, 3, 4, 1};
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("rr.lp_ready%0d", i), 64'(lp_ready), 64'(4'b0001 << (exp_src[i] - 1)));
            tick();
            check_out($sformatf("rr.out%0d", i), 1'b1, 3'(exp_src[i]));
            check($sformatf("rr.value%0d", i), cdb_value, 64'h100 + 64'(exp_src[i] - 1));
        end
        check("rr.rr_ptr", 64'(dbg_rr_ptr), 64'd1);

        // No grant: valid drops the next cycle.
        lp_valid = 4'b0000;
        tick();
        check("idle.cdb_valid", 64'(cdb_valid), 64'd0);

        // Anti-starvation: mp held, source 2 held.
        mp_valid = 1'b1;
        lp_valid = 4'b0100;
        ast_src = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 3};
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out($sformatf("ast.out%0d", i), 1'b1, 3'(ast_src[i]));
        end
        check("ast.rr_ptr", 64'(dbg_rr_ptr), 64'd3);
        check("ast.streak", 64'(dbg_streak), 64'd0);

        mp_valid = 1'b0;
        lp_valid = 4'b0000;
        tick();
        check("ast.idle", 64'(cdb_valid), 64'd0);

        // Backpressure: mp result held while the ROB stalls.
        mp_valid   = 1'b1;
        mp_rob_idx = 6'd5;
        mp_value   = 64'hDEAD;
        cdb_ready  = 1'b0;
        tick();
        check_out("bp.load", 1'b1, 3'd0);
        check("bp.load.value", cdb_value, 64'hDEAD);
        mp_valid = 1'b0;
        lp_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("bp.mp_ready%0d", i), 64'(mp_ready), 64'd0);
            check($sformatf("bp.lp_ready%0d", i), 64'(lp_ready), 64'd0);
            tick();
            check_out($sformatf("bp.hold%0d", i), 1'b1, 3'd0);
            check($sformatf("bp.hold_value%0d", i), cdb_value, 64'hDEAD);
            check($sformatf("bp.hold_rob%0d", i), 64'(cdb_rob_idx), 64'd5);
        end
        cdb_ready = 1'b1;
        settle();
        check("bp.drain_lp_ready", 64'(lp_ready), 64'b0010);
        tick();
        check_out("bp.b2b", 1'b1, 3'd2);
        check("bp.b2b_value", cdb_value, 64'h101);
        check("bp.rr_ptr", 64'(dbg_rr_ptr), 64'd2);

        // Build up a streak, then flush with the ROB draining.
        mp_valid = 1'b1;
        mp_value = 64'hBEEF;
        lp_valid = 4'b0001;
        tick();
        check_out("fl.pre", 1'b1, 3'd0);
        check("fl.pre_streak", 64'(dbg_streak), 64'd1);
        flush = 1'b1;
        settle();
        check("fl.mp_ready", 64'(mp_ready), 64'd0);
        check("fl.lp_ready", 64'(lp_ready), 64'd0);
        tick();
        check("fl.cdb_valid", 64'(cdb_valid), 64'd0);
        check("fl.streak", 64'(dbg_streak), 64'd0);
        check("fl.rr_ptr", 64'(dbg_rr_ptr), 64'd2);
        flush = 1'b0;
        mp_valid = 1'b0;

        // Wrap-around and exception pass-through.
        lp_valid = 4'b0100;
        tick();
        check_out("wr.set", 1'b1, 3'd3);
        check("wr.rr_ptr3", 64'(dbg_rr_ptr), 64'd3);
        lp_valid  = 4'b1001;
        lp_except = 4'b0001;
        settle();
        check("wr.lp_ready_a", 64'(lp_ready), 64'b1000);
        tick();
        check_out("wr.first", 1'b1, 3'd4);
        check("wr.first_except", 64'(cdb_except), 64'd0);
        check("wr.rr_ptr0", 64'(dbg_rr_ptr), 64'd0);
        lp_valid = 4'b0001;
        settle();
        check("wr.lp_ready_b", 64'(lp_ready), 64'b0001);
        tick();
        check_out("wr.second", 1'b1, 3'd1);
        check("wr.second_except", 64'(cdb_except), 64'd1);
        check("wr.second_rob", 64'(cdb_rob_idx), 64'd10);
        check("wr.rr_ptr1", 64'(dbg_rr_ptr), 64'd1);

        // Reset wins over flush and returns rr_ptr to 0.
        lp_valid = 4'b0000;
        lp_except = 4'b0000;
        rst = 1'b1;
        flush = 1'b1;
        tick();
        check("rf.cdb_valid", 64'(cdb_valid), 64'd0);
        check("rf.rr_ptr", 64'(dbg_rr_ptr), 64'd0);
        check("rf.value", cdb_value, 64'd0);
        rst = 1'b0;
        flush = 1'b0;
        tick();

        // Report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
